// File: rtl/pe_feed_pkg.sv
// pe_feed_pkg: default chain geometry and FSM state encoding for the PE chain feeder
package pe_feed_pkg;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CHAIN_LEN = 9;
    typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, FIRE, DONE} state_t;
endpackage

// File: rtl/pe_chain_feeder.sv
// pe_chain_feeder: shifts one window per job into the PE chain, then fires the masked enable
module pe_chain_feeder
    import pe_feed_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] en_mask,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 pe_valid,
    output logic [DATA_W-1:0]    pe_data,
    output logic [CHAIN_LEN-1:0] pe_enable,
    output logic                 fire,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len
);
    localparam logic [CNT_W-1:0] TAIL = CNT_W'(CHAIN_LEN - 1);
    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]    data_d;
    logic                 valid_d, err_d, take;
    assign in_ready  = (state == LOAD) || (state == DRAIN);
    assign take      = in_valid && in_ready;
    assign fire      = state == FIRE;
    assign pe_enable = fire ? mask_q : '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    // cnt counts shifts issued; the beat at index TAIL is the tail word and never shifts
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mask_d  = mask_q;
        data_d  = pe_data;
        valid_d = 1'b0;
        err_d   = err_len;
        case (state)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d   = '0;
                mask_d  = en_mask;
                err_d   = 1'b0;
            end
            LOAD: if (take) begin
                data_d  = in_data;
                cnt_d   = cnt + 1'b1;
                valid_d = cnt != TAIL;
                if (cnt == TAIL) begin
                    state_d = in_last ? FIRE : DRAIN;
                    err_d   = !in_last;
                end else if (in_last) begin
                    state_d = PAD;
                    err_d   = 1'b1;
                end
            end
            PAD: begin
                data_d  = '0;
                valid_d = cnt != TAIL;
                cnt_d   = cnt + 1'b1;
                state_d = (cnt == TAIL) ? FIRE : PAD;
            end
            DRAIN:   state_d = (take && in_last) ? FIRE : DRAIN;
            FIRE:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mask_q   <= '0;
            pe_data  <= '0;
            pe_valid <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            mask_q   <= mask_d;
            pe_data  <= data_d;
            pe_valid <= valid_d;
            err_len  <= err_d;
        end
    end
endmodule

// File: tb/tb_pe_chain_feeder.sv
// tb_pe_chain_feeder: directed checks of the feeder against a behavioural 9-stage PE chain
module tb_pe_chain_feeder;
    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_last;
    logic [8:0] en_mask;
    logic [7:0] in_data;
    logic       in_ready, pe_valid, fire, busy, done, err_len;
    logic [7:0] pe_data;
    logic [8:0] pe_enable;
    logic [7:0] stage [0:7];
    int         pulse_total = 0;
    int         checks = 0;
    int         errors = 0;

    pe_chain_feeder dut (
        .clk(clk), .rst(rst), .start(start), .en_mask(en_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .pe_valid(pe_valid), .pe_data(pe_data), .pe_enable(pe_enable),
        .fire(fire), .busy(busy), .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // PE register chain: PE[0] multiplies pe_data directly, PE[j] multiplies stage[j-1]
    always @(posedge clk) begin
        if (pe_valid) begin
            for (int k = 7; k > 0; k--) stage[k] <= stage[k-1];
            stage[0]    <= pe_data;
            pulse_total <= pulse_total + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic run_job(input logic [8:0] mask, input int n, input bit gaps,
                           output int pulses, output logic [71:0] mult, output logic err,
                           output int lat, output bit done_ok, output bit ready_ok, output int bad);
        int  p0, i, cyc, last_cyc;
        bit  acc;
        p0 = pulse_total;
        i = 0; cyc = 0; last_cyc = -100; lat = -1;
        done_ok = 1'b0; ready_ok = 1'b1; bad = 0; mult = '0; err = 1'bx;
        start = 1'b1; en_mask = mask;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fire && cyc < 300) begin
            in_valid = (i < n) && (!gaps || (cyc % 2 == 0));
            in_data  = 8'(i + 1);
            in_last  = (i == n - 1);
            if (i < n && !in_ready) ready_ok = 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (pe_valid && !acc) bad++;
            if (acc) begin
                i++;
                last_cyc = cyc;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (fire) begin
            lat = cyc - last_cyc;
            mult[7:0] = pe_enable[0] ? pe_data : 8'd0;
            for (int j = 1; j < 9; j++) mult[j*8 +: 8] = pe_enable[j] ? stage[j-1] : 8'd0;
        end
        err    = err_len;
        pulses = pulse_total - p0;
        start  = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        done_ok = (done === 1'b1) && (fire === 1'b0) && (pe_enable === 9'h0) && (busy === 1'b1);
        @(posedge clk); #1;
        done_ok = done_ok && (busy === 1'b0) && (done === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; en_mask = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, pe_valid, pe_data, pe_enable, fire, busy, done, err_len} !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {in_ready, pe_valid, pe_data, pe_enable, fire, busy, done, err_len});
        end
    endtask

    task automatic test_nominal();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        run_job(9'h1FF, 9, 1'b0, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h01_02_03_04_05_06_07_08_09) begin errors++; $display("FAIL nominal_window got %h want 010203040506070809", m); end
        checks++; if (p !== 8) begin errors++; $display("FAIL nominal_pulses got %0d want 8", p); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL nominal_err got %b want 0", e); end
        checks++; if (l !== 0) begin errors++; $display("FAIL nominal_fire_latency got %0d want 0", l); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL nominal_done got %b want 1", d); end
    endtask

    task automatic test_mask();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        run_job(9'h0AA, 9, 1'b0, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h00_02_00_04_00_06_00_08_00) begin errors++; $display("FAIL mask_window got %h want 000200040006000800", m); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL mask_done got %b want 1", d); end
    endtask

    task automatic test_short();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        run_job(9'h1FF, 5, 1'b0, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h01_02_03_04_05_00_00_00_00) begin errors++; $display("FAIL short_window got %h want 010203040500000000", m); end
        checks++; if (p !== 8) begin errors++; $display("FAIL short_pulses got %0d want 8", p); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", e); end
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err_sticky got %b want 1", err_len); end
    endtask

    task automatic test_long();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        run_job(9'h1FF, 12, 1'b0, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h01_02_03_04_05_06_07_08_09) begin errors++; $display("FAIL long_window got %h want 010203040506070809", m); end
        checks++; if (p !== 8) begin errors++; $display("FAIL long_pulses got %0d want 8", p); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL long_err got %b want 1", e); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL long_ready_held got %b want 1", r); end
    endtask

    task automatic test_gaps();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        run_job(9'h1FF, 9, 1'b1, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h01_02_03_04_05_06_07_08_09) begin errors++; $display("FAIL gaps_window got %h want 010203040506070809", m); end
        checks++; if (p !== 8) begin errors++; $display("FAIL gaps_pulses got %0d want 8", p); end
        checks++; if (b !== 0) begin errors++; $display("FAIL gaps_unaccepted_pulses got %0d want 0", b); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL gaps_err_cleared got %b want 0", e); end
    endtask

    task automatic test_rst_mid();
        int p, l, b; logic [71:0] m; logic e; bit d, r;
        start = 1'b1; en_mask = 9'h1FF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1); in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_data = 8'd4; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, pe_valid, pe_data, pe_enable, fire, busy, done, err_len} !== 23'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %h want 0",
                     {in_ready, pe_valid, pe_data, pe_enable, fire, busy, done, err_len});
        end
        @(posedge clk); #1;
        run_job(9'h1FF, 9, 1'b0, p, m, e, l, d, r, b);
        checks++; if (m !== 72'h01_02_03_04_05_06_07_08_09) begin errors++; $display("FAIL rst_mid_window got %h want 010203040506070809", m); end
        checks++; if (p !== 8) begin errors++; $display("FAIL rst_mid_pulses got %0d want 8", p); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mask();
        test_short();
        test_long();
        test_gaps();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
